gsim_param: RTL and testbench

GSIM_PARAM -- requirements
Module: gsim_param

---
 rtl/gsim_pkg.sv | 29 ++
 rtl/gsim_row_update.sv | 48 ++++
 rtl/gsim_param.sv | 161 ++++++++++++++++
 tb/tb_gsim_param.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gsim_pkg.sv
// gsim_pkg: state encoding, banded-matrix coefficients, reciprocal and default
// parameters shared by the Gauss-Seidel solver files.
package gsim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ITER,
        ST_OUT
    } state_t;

    // Matrix rows: 20 on the diagonal, -13 / +6 / -1 at distance 1 / 2 / 3.
    localparam int COEF_D = 20;
    localparam int COEF_1 = 13;
    localparam int COEF_2 = 6;
    localparam int COEF_3 = 1;

    localparam int unsigned RSH     = 24;
    localparam int          RECIP   = ((1 << RSH) + COEF_D / 2) / COEF_D;
    localparam int unsigned RECIP_W = 21;

    localparam int unsigned DEF_N       = 16;
    localparam int unsigned DEF_B_W     = 16;
    localparam int unsigned DEF_X_W     = 32;
    localparam int unsigned DEF_FRAC    = 16;
    localparam int unsigned DEF_ITER    = 256;
    localparam int unsigned DEF_CONV_TH = 0;

endpackage

// File: rtl/gsim_row_update.sv
// gsim_row_update: combinational Gauss-Seidel row update for the banded matrix:
// neighbour sum, multiply by the reciprocal of the diagonal, round, saturate.
module gsim_row_update
    import gsim_pkg::*;
#(
    parameter int unsigned B_W  = DEF_B_W,
    parameter int unsigned X_W  = DEF_X_W,
    parameter int unsigned FRAC = DEF_FRAC
) (
    input  logic signed [B_W-1:0] b,
    input  logic signed [X_W-1:0] xm1,
    input  logic signed [X_W-1:0] xp1,
    input  logic signed [X_W-1:0] xm2,
    input  logic signed [X_W-1:0] xp2,
    input  logic signed [X_W-1:0] xm3,
    input  logic signed [X_W-1:0] xp3,
    output logic signed [X_W-1:0] x_new
);
    localparam int unsigned S_W = X_W + 6;
    localparam int unsigned P_W = S_W + RECIP_W;

    logic signed [S_W-1:0] t1;
    logic signed [S_W-1:0] t2;
    logic signed [S_W-1:0] t3;
    logic signed [S_W-1:0] s;
    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] rnd;
    logic signed [P_W-1:0] shr;

    always_comb begin
        t1   = S_W'(xm1) + S_W'(xp1);
        t2   = S_W'(xm2) + S_W'(xp2);
        t3   = S_W'(xm3) + S_W'(xp3);
        s    = (S_W'(b) <<< FRAC) + S_W'(COEF_1) * t1 - S_W'(COEF_2) * t2 + S_W'(COEF_3) * t3;
        prod = P_W'(s) * P_W'(RECIP);
        rnd  = prod + (P_W'(1) <<< (RSH - 1));
        shr  = rnd >>> RSH;
        // In range when every bit above the X_W sign bit matches it.
        if (shr[P_W-1:X_W-1] == '0 || shr[P_W-1:X_W-1] == '1) begin
            x_new = shr[X_W-1:0];
        end else if (shr[P_W-1]) begin
            x_new = {1'b1, {(X_W-1){1'b0}}};
        end else begin
            x_new = {1'b0, {(X_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/gsim_param.sv
// gsim_param: loads b, runs in-place Gauss-Seidel sweeps, streams out x[0..N-1].
// Define GSIM_CONV_EN to leave early once a sweep changes no x by more than CONV_TH.
module gsim_param
    import gsim_pkg::*;
#(
    parameter int unsigned N    = DEF_N,
    parameter int unsigned B_W  = DEF_B_W,
    parameter int unsigned X_W  = DEF_X_W,
    parameter int unsigned FRAC = DEF_FRAC,
    parameter int unsigned ITER = DEF_ITER
`ifdef GSIM_CONV_EN
    ,
    parameter int unsigned CONV_TH = DEF_CONV_TH
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_en,
    input  logic signed [B_W-1:0] b_in,
    output logic                  busy,
    output logic                  out_valid,
    output logic signed [X_W-1:0] x_out
);
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned SW = $clog2(ITER + 1);
    localparam logic [AW-1:0] LAST_IDX   = AW'(N - 1);
    localparam logic [SW-1:0] LAST_SWEEP = SW'(ITER - 1);

    state_t                state;
    logic [AW-1:0]         idx;
    logic [SW-1:0]         sweep;
    logic                  out_done;
    logic signed [X_W-1:0] x_mem [N];
    logic signed [B_W-1:0] b_mem [N];
    logic signed [X_W-1:0] x_lo  [1:3];
    logic signed [X_W-1:0] x_hi  [1:3];
    logic signed [X_W-1:0] x_new;
    logic                  converged;

    // Neighbours outside 0..N-1 read as zero.
    for (genvar d = 1; d <= 3; d++) begin : g_nb
        assign x_lo[d] = (int'(idx) >= d) ? x_mem[idx - AW'(d)] : '0;
        assign x_hi[d] = (int'(idx) + d < int'(N)) ? x_mem[idx + AW'(d)] : '0;
    end

    gsim_row_update #(
        .B_W  (B_W),
        .X_W  (X_W),
        .FRAC (FRAC)
    ) u_row (
        .b     (b_mem[idx]),
        .xm1   (x_lo[1]),
        .xp1   (x_hi[1]),
        .xm2   (x_lo[2]),
        .xp2   (x_hi[2]),
        .xm3   (x_lo[3]),
        .xp3   (x_hi[3]),
        .x_new (x_new)
    );

`ifdef GSIM_CONV_EN
    localparam int unsigned DW = X_W + 1;

    logic signed [DW-1:0] diff;
    logic [DW-1:0]        cur_d;
    logic [DW-1:0]        max_d;
    logic [DW-1:0]        sweep_max;

    // Largest |x_new - x_old| of the sweep, including the row being written now.
    always_comb begin
        diff      = DW'(x_new) - DW'(x_mem[idx]);
        cur_d     = diff[DW-1] ? DW'(-diff) : DW'(diff);
        sweep_max = (cur_d > max_d) ? cur_d : max_d;
        converged = (sweep_max <= DW'(CONV_TH));
    end
`else
    assign converged = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            sweep     <= '0;
            out_done  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            x_out     <= '0;
            x_mem     <= '{default: '0};
            b_mem     <= '{default: '0};
`ifdef GSIM_CONV_EN
            max_d     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    out_valid <= 1'b0;
                    x_out     <= '0;
                    if (in_en) begin
                        b_mem[0] <= b_in;
                        x_mem    <= '{default: '0};
                        idx      <= AW'(1);
                        busy     <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (in_en) begin
                        b_mem[idx] <= b_in;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            sweep <= '0;
                            state <= ST_ITER;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
                ST_ITER: begin
                    x_mem[idx] <= x_new;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        sweep <= sweep + SW'(1);
                        if (sweep == LAST_SWEEP || converged) begin
                            out_done <= 1'b0;
                            state    <= ST_OUT;
                        end
                    end else begin
                        idx <= idx + AW'(1);
                    end
`ifdef GSIM_CONV_EN
                    max_d <= (idx == LAST_IDX) ? '0 : sweep_max;
`endif
                end
                ST_OUT: begin
                    // N valid beats, then one beat to drop out_valid and return to IDLE.
                    if (!out_done) begin
                        out_valid <= 1'b1;
                        x_out     <= x_mem[idx];
                        if (idx == LAST_IDX) begin
                            out_done <= 1'b1;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end else begin
                        out_valid <= 1'b0;
                        x_out     <= '0;
                        busy      <= 1'b0;
                        idx       <= '0;
                        out_done  <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gsim_param.sv
// tb_gsim_param: scoreboard bench for gsim_param (N=16/ITER=256 and N=4/ITER=1)
// against a plain-arithmetic Gauss-Seidel reference model.
module tb_gsim_param;

    localparam int N_A  = 16;
    localparam int IT_A = 256;
    localparam int N_B  = 4;
    localparam int IT_B = 1;
    localparam longint RCP = ((64'sd1 <<< 24) + 10) / 20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic               en_a, en_b;
    logic signed [15:0] b_a, b_b;
    logic               busy_a, busy_b, ov_a, ov_b;
    logic signed [31:0] x_a, x_b;

    gsim_param #(.N(N_A), .B_W(16), .X_W(32), .FRAC(16), .ITER(IT_A)) u_a (
        .clk(clk), .reset(reset), .in_en(en_a), .b_in(b_a),
        .busy(busy_a), .out_valid(ov_a), .x_out(x_a)
    );

    gsim_param #(.N(N_B), .B_W(16), .X_W(32), .FRAC(16), .ITER(IT_B)) u_b (
        .clk(clk), .reset(reset), .in_en(en_b), .b_in(b_b),
        .busy(busy_b), .out_valid(ov_b), .x_out(x_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     checks = 0;
    int     errors = 0;
    longint exp_a[$], exp_b[$];
    longint got_a[$], got_b[$];
    longint base_a[$];
    bit     first_a = 0, first_b = 0;
    int     t0_a = 0, t0_b = 0;
    int     lat_a = -1, lat_b = -1;

    function automatic void chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endfunction

    function automatic longint xat(input longint x[64], input int n, input int j);
        return (j < 0 || j >= n) ? 64'sd0 : x[j];
    endfunction

    function automatic int coef(input int d);
        int a;
        a = (d < 0) ? -d : d;
        case (a)
            0: return 20;
            1: return -13;
            2: return 6;
            3: return -1;
            default: return 0;
        endcase
    endfunction

    // Gauss-Seidel on M*x=b in Q16.16 with round-half-up and 32-bit saturation.
    function automatic void model(input int bv[$], input int iter, output longint xs[$], output int sweeps);
        longint x[64];
        longint s, q, d, maxd;
        int     n;
        n = bv.size();
        for (int i = 0; i < 64; i++) x[i] = 0;
        sweeps = 0;
        for (int k = 0; k < iter; k++) begin
            maxd = 0;
            for (int i = 0; i < n; i++) begin
                s = (longint'(bv[i]) <<< 16)
                    + 13 * (xat(x, n, i - 1) + xat(x, n, i + 1))
                    - 6  * (xat(x, n, i - 2) + xat(x, n, i + 2))
                    +      (xat(x, n, i - 3) + xat(x, n, i + 3));
                q = (s * RCP + (64'sd1 <<< 23)) >>> 24;
                if (q > 64'sd2147483647)  q = 64'sd2147483647;
                if (q < -64'sd2147483648) q = -64'sd2147483648;
                d = q - x[i];
                if (d < 0) d = -d;
                if (d > maxd) maxd = d;
                x[i] = q;
            end
            sweeps++;
`ifdef GSIM_CONV_EN
            if (maxd <= 0) break;
`endif
        end
        xs = {};
        for (int i = 0; i < n; i++) xs.push_back(x[i]);
    endfunction

    task automatic mon_a();
        if (ov_a) begin
            if (first_a) begin
                first_a = 0;
                if (lat_a >= 0) chk("latency_a", longint'(cyc - t0_a), longint'(lat_a));
            end
            if (exp_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_valid_a got x=%0d expected no out_valid", x_a);
            end else begin
                chk($sformatf("x_a[%0d]", got_a.size()), longint'(x_a), exp_a.pop_front());
                got_a.push_back(longint'(x_a));
            end
        end
    endtask

    task automatic mon_b();
        if (ov_b) begin
            if (first_b) begin
                first_b = 0;
                if (lat_b >= 0) chk("latency_b", longint'(cyc - t0_b), longint'(lat_b));
            end
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_valid_b got x=%0d expected no out_valid", x_b);
            end else begin
                chk($sformatf("x_b[%0d]", got_b.size()), longint'(x_b), exp_b.pop_front());
                got_b.push_back(longint'(x_b));
            end
        end
    endtask

    // Push expectations, then drive b; 'now' drives the first element without waiting a negedge.
    task automatic load(input bit u, input int bv[$], input int gap, input bit chk_lat, input bit now);
        longint xs[$];
        int     sw;
        model(bv, u ? IT_B : IT_A, xs, sw);
        if (u) begin
            foreach (xs[i]) exp_b.push_back(xs[i]);
            got_b = {}; first_b = 1; lat_b = chk_lat ? bv.size() * (sw + 1) : -1;
        end else begin
            foreach (xs[i]) exp_a.push_back(xs[i]);
            got_a = {}; first_a = 1; lat_a = chk_lat ? bv.size() * (sw + 1) : -1;
        end
        for (int i = 0; i < bv.size(); i++) begin
            if (i > 0 || !now) @(negedge clk);
            if (u) begin en_b = 1'b1; b_b = 16'(bv[i]); end
            else   begin en_a = 1'b1; b_a = 16'(bv[i]); end
            @(posedge clk);
            #1;
            if (i == 0) begin
                if (u) t0_b = cyc; else t0_a = cyc;
            end
            if (gap > 0 && i < bv.size() - 1) begin
                @(negedge clk);
                if (u) en_b = 1'b0; else en_a = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        if (u) en_b = 1'b0; else en_a = 1'b0;
    endtask

    task automatic wait_done(input bit u, input int budget);
        int k = 0;
        forever begin
            @(negedge clk);
            k++;
            if (u ? (!busy_b && exp_b.size() == 0) : (!busy_a && exp_a.size() == 0)) break;
            if (k >= budget) begin
                checks++; errors++;
                $display("FAIL timeout_%s got %0d outputs pending expected 0 within %0d cycles",
                         u ? "b" : "a", u ? exp_b.size() : exp_a.size(), budget);
                if (u) exp_b = {}; else exp_a = {};
                break;
            end
        end
    endtask

    initial begin
        int   std_b[$];
        int   zero_b[$];
        int   rv[$];
        int   one_b[$];
        real  res, acc;
        real  tgt[4];

        std_b  = '{100, -200, 300, 50, -75, 125, 0, 400, -350, 10, 20, -30, 250, -125, 60, -5};
        zero_b = {};
        for (int i = 0; i < N_A; i++) zero_b.push_back(0);
        one_b  = '{20, 0, 0, 0};
        tgt    = '{1.0, 0.65, 0.1225, -0.065375};

        reset = 1'b0; en_a = 1'b0; en_b = 1'b0; b_a = '0; b_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy_a", longint'(busy_a), 0);
        chk("reset_valid_a", longint'(ov_a), 0);
        chk("reset_x_a", longint'(x_a), 0);
        chk("reset_busy_b", longint'(busy_b), 0);
        chk("reset_valid_b", longint'(ov_b), 0);
        chk("reset_x_b", longint'(x_b), 0);
        reset = 1'b1;

        fork
            forever begin @(negedge clk); mon_a(); end
            forever begin @(negedge clk); mon_b(); end
        join_none

        // Baseline solve plus residual of the returned x.
        load(0, std_b, 0, 1, 0);
        wait_done(0, 6000);
        base_a = got_a;
        chk("baseline_count", longint'(got_a.size()), N_A);
        res = 0.0;
        if (got_a.size() == N_A) begin
            for (int i = 0; i < N_A; i++) begin
                acc = -real'(std_b[i]);
                for (int j = i - 3; j <= i + 3; j++)
                    if (j >= 0 && j < N_A) acc += real'(coef(i - j)) * real'(got_a[j]) / 65536.0;
                res += acc * acc;
            end
        end else begin
            res = 1.0;
        end
        checks++;
        if (!(res < 1e-6)) begin
            errors++;
            $display("FAIL residual got %e expected below 1e-6", res);
        end

        // All-zero b: zero result and exact latency.
        load(0, zero_b, 0, 1, 0);
        wait_done(0, 6000);

        // Gapped load with in_en activity while busy must match the gapless result.
        load(0, std_b, 3, 0, 0);
        repeat (300) begin
            @(negedge clk);
            en_a = 1'($urandom_range(0, 1));
            b_a  = 16'($urandom_range(0, 65535));
        end
        @(negedge clk);
        en_a = 1'b0;
        wait_done(0, 6000);
        chk("gap_count", longint'(got_a.size()), longint'(base_a.size()));
        for (int i = 0; i < N_A && i < got_a.size() && i < base_a.size(); i++)
            chk($sformatf("gap_vs_base[%0d]", i), got_a[i], base_a[i]);

        // Abort mid-ITER, make sure nothing comes out, then solve again.
        rv = {};
        for (int i = 0; i < N_A; i++) rv.push_back(int'($urandom_range(0, 4000)) - 2000);
        load(0, rv, 0, 0, 0);
        repeat (200) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_busy", longint'(busy_a), 0);
        chk("abort_valid", longint'(ov_a), 0);
        chk("abort_x", longint'(x_a), 0);
        exp_a = {}; first_a = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (4400) @(negedge clk);
        chk("abort_idle", longint'(busy_a), 0);
        load(0, std_b, 0, 1, 0);
        wait_done(0, 6000);
        for (int i = 0; i < N_A && i < got_a.size(); i++)
            chk($sformatf("after_abort[%0d]", i), got_a[i], base_a[i]);

        // Single sweep on N=4 against the hand-derived values.
        load(1, one_b, 0, 1, 0);
        wait_done(1, 200);
        for (int i = 0; i < N_B; i++) begin
            longint t;
            t = longint'($rtoi(tgt[i] * 65536.0));
            checks++;
            if (i >= got_b.size() || got_b[i] - t > 1 || t - got_b[i] > 1) begin
                errors++;
                $display("FAIL single_sweep[%0d] got %0d expected %0d +-1",
                         i, (i < got_b.size()) ? got_b[i] : 64'sd0, t);
            end
        end

        // Random back-to-back loads, each started in the first IDLE cycle.
        for (int r = 0; r < 20; r++) begin
            rv = {};
            for (int i = 0; i < N_B; i++) rv.push_back(int'($urandom_range(0, 65535)) - 32768);
            load(1, rv, 0, 1, 1);
            wait_done(1, 200);
        end

        // Random solves on the large instance.
        for (int r = 0; r < 2; r++) begin
            rv = {};
            for (int i = 0; i < N_A; i++) rv.push_back(int'($urandom_range(0, 4000)) - 2000);
            load(0, rv, 0, 1, 0);
            wait_done(0, 6000);
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
